// File: rtl/diff_block.sv
// Multi-cycle 32-bit subtractor that processes STEP bits per cycle, LSB-first.
// Optional signed-overflow flag enabled by defining DIFF_BLOCK_OVF_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start; operands are latched on the start edge
// ST_RUN   | one STEP-bit chunk per cycle, borrow carried chunk to chunk
// ST_DONE  | result visible on out, one-cycle done pulse
module diff_block #(
   parameter int STEP = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        borrow_in,
   output logic        busy,
   output logic        done,
   output logic [32:0] out,
   output logic        ovf
);

   localparam int         N_CHUNKS = 32 / STEP;
   localparam logic [5:0] LAST_CNT = 6'(N_CHUNKS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [5:0]    cnt_q, cnt_d;
   logic [31:0]   a_q, a_d;
   logic [31:0]   b_q, b_d;
   logic          bin_q, bin_d;
   logic          borrow_q, borrow_d;
   logic [31:0]   diff_q, diff_d;
   logic [32:0]   out_q, out_d;

   logic [STEP-1:0]   chunk_a;
   logic [STEP-1:0]   chunk_b;
   logic              chunk_bin;
   logic [STEP:0]     chunk_res;
   logic [31+STEP:0]  diff_shift;
   logic [31:0]       diff_next;

   // Operands shift right each RUN cycle, so the active chunk is always at the bottom
   assign chunk_a    = a_q[STEP-1:0];
   assign chunk_b    = b_q[STEP-1:0];
   assign chunk_bin  = (cnt_q == 6'd0) ? bin_q : borrow_q;
   assign chunk_res  = {1'b0, chunk_a} - {1'b0, chunk_b} - {{STEP{1'b0}}, chunk_bin};
   assign diff_shift = {chunk_res[STEP-1:0], diff_q};
   assign diff_next  = diff_shift[31+STEP:STEP];

`ifdef DIFF_BLOCK_OVF_EN
   logic a_msb_q, a_msb_d;
   logic b_msb_q, b_msb_d;
   logic ovf_q, ovf_d;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      bin_d    = bin_q;
      borrow_d = borrow_q;
      diff_d   = diff_q;
      out_d    = out_q;
`ifdef DIFF_BLOCK_OVF_EN
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      ovf_d    = ovf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_RUN;
               cnt_d    = 6'd0;
               a_d      = a;
               b_d      = b;
               bin_d    = borrow_in;
               borrow_d = 1'b0;
               diff_d   = 32'h0;
`ifdef DIFF_BLOCK_OVF_EN
               a_msb_d  = a[31];
               b_msb_d  = b[31];
`endif
            end
         end
         ST_RUN: begin
            a_d      = a_q >> STEP;
            b_d      = b_q >> STEP;
            borrow_d = chunk_res[STEP];
            diff_d   = diff_next;
            cnt_d    = cnt_q + 6'd1;
            if (cnt_q == LAST_CNT) begin
               state_d = ST_DONE;
               out_d   = {chunk_res[STEP], diff_next};
`ifdef DIFF_BLOCK_OVF_EN
               ovf_d   = (a_msb_q != b_msb_q) && (diff_next[31] != a_msb_q);
`endif
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 6'd0;
         a_q      <= 32'h0;
         b_q      <= 32'h0;
         bin_q    <= 1'b0;
         borrow_q <= 1'b0;
         diff_q   <= 32'h0;
         out_q    <= 33'h0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         bin_q    <= bin_d;
         borrow_q <= borrow_d;
         diff_q   <= diff_d;
         out_q    <= out_d;
      end
   end

`ifdef DIFF_BLOCK_OVF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign out  = out_q;

endmodule

// File: tb/tb_diff_block.sv
// Directed bench for diff_block: one instance at STEP=1 and one at STEP=4.
// Expected ovf follows DIFF_BLOCK_OVF_EN.
module tb_diff_block;

`ifdef DIFF_BLOCK_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst1, start1, bin1;
   logic [31:0] a1, b1;
   logic        busy1, done1, ovf1;
   logic [32:0] out1;
   logic        rst4, start4, bin4;
   logic [31:0] a4, b4;
   logic        busy4, done4, ovf4;
   logic [32:0] out4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   diff_block #(.STEP(1)) dut1 (
      .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .borrow_in(bin1),
      .busy(busy1), .done(done1), .out(out1), .ovf(ovf1)
   );

   diff_block #(.STEP(4)) dut4 (
      .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .borrow_in(bin4),
      .busy(busy4), .done(done4), .out(out4), .ovf(ovf4)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full STEP=1 operation; operands are scrambled after acceptance.
   task automatic run1(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic bi, input logic [32:0] exp_out, input logic exp_ovf);
      int edges;
      int busy_cnt;
      logic [32:0] prev_out;
      logic [32:0] mid_out;
      prev_out = out1;
      mid_out  = out1;
      a1 = av; b1 = bv; bin1 = bi; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      a1 = 32'hDEAD_BEEF; b1 = 32'h1357_9BDF; bin1 = ~bi;
      edges = 0;
      busy_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (busy1) busy_cnt++;
         tick();
         edges++;
         if (edges == 10) mid_out = out1;
         if (done1) break;
      end
      check({tag, "_latency"}, 64'(edges), 64'd32);
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
      check({tag, "_out_hold"}, 64'(mid_out), 64'(prev_out));
      check({tag, "_out"}, 64'(out1), 64'(exp_out));
      check({tag, "_ovf"}, 64'(ovf1), 64'(exp_ovf));
      check({tag, "_busy_in_done"}, 64'(busy1), 64'd0);
      tick();
      check({tag, "_done_one_cycle"}, 64'(done1), 64'd0);
      check({tag, "_out_kept"}, 64'(out1), 64'(exp_out));
   endtask

   initial begin
      int dones;
      int done_edge;
      rst1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
      rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
      tick();
      tick();
      check("reset_busy", 64'(busy1), 64'd0);
      check("reset_done", 64'(done1), 64'd0);
      check("reset_out", 64'(out1), 64'd0);
      check("reset_ovf", 64'(ovf1), 64'd0);
      rst1 = 1'b0;
      rst4 = 1'b0;
      tick();

      // Abort at RUN cycle 10
      a1 = 32'd5; b1 = 32'd3; bin1 = 1'b0; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      check("abort_busy_before", 64'(busy1), 64'd1);
      rst1 = 1'b1;
      tick();
      rst1 = 1'b0;
      check("abort_busy_after", 64'(busy1), 64'd0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (done1) dones++;
         tick();
      end
      check("abort_no_done", 64'(dones), 64'd0);
      check("abort_out", 64'(out1), 64'd0);

      run1("sub_5_3", 32'd5, 32'd3, 1'b0, 33'h0_0000_0002, 1'b0);
      run1("sub_0_1", 32'd0, 32'd1, 1'b0, 33'h1_FFFF_FFFF, 1'b0);
      run1("sub_eq_bin", 32'h10, 32'h10, 1'b1, 33'h1_FFFF_FFFF, 1'b0);
      run1("sub_min_1", 32'h8000_0000, 32'd1, 1'b0, 33'h0_7FFF_FFFF, OVF_ON);
      run1("sub_max_neg1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33'h1_8000_0000, OVF_ON);

      // STEP=4: second start pulse at RUN cycle 3 must be ignored
      a4 = 32'hFFFF_FFFF; b4 = 32'h1234_5678; bin4 = 1'b0; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      a4 = 32'h0; b4 = 32'hFFFF_FFFF;
      dones = 0;
      done_edge = 0;
      for (int e = 1; e <= 24; e++) begin
         start4 = (e == 3);
         tick();
         if (done4) begin
            dones++;
            if (done_edge == 0) done_edge = e;
         end
      end
      start4 = 1'b0;
      check("step4_done_count", 64'(dones), 64'd1);
      check("step4_done_edge", 64'(done_edge), 64'd8);
      check("step4_out", 64'(out4), 64'h0_EDCB_A987);
      check("step4_ovf", 64'(ovf4), 64'd0);
      check("step4_idle", 64'(busy4), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/diff_block.md
DIFF_BLOCK -- requirements
Module: diff_block

Interface
REQ-001 The block SHALL have parameter STEP, default 1, giving the bits processed per RUN cycle; legal values are 1, 2, 4, 8, 16 and 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: a request to begin a subtraction.
REQ-005 The block SHALL have port a, input, 32 bits: the minuend.
REQ-006 The block SHALL have port b, input, 32 bits: the subtrahend.
REQ-007 The block SHALL have port borrow_in, input, 1 bit: the incoming borrow.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-010 The block SHALL have port out, output, 33 bits: out[31:0] is the difference and out[32] is the borrow-out.
REQ-011 The block SHALL have port ovf, output, 1 bit: the signed overflow flag (see Configuration).

Function
REQ-012 The result SHALL be computed as a - b - borrow_in, modulo 2^32, into out[31:0]; out[32] SHALL be 1 when a < b + borrow_in (unsigned).
REQ-013 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1 on an edge, the block SHALL latch a, b and borrow_in, clear the chunk counter and the internal borrow, and move to RUN.
REQ-015 The block SHALL ignore later changes of a, b and borrow_in after the acceptance edge.
REQ-016 In RUN, each cycle SHALL process STEP bits, LSB-first, ripple-borrow within the chunk, with the chunk borrow registered into the next chunk.
REQ-017 After 32/STEP RUN cycles the block SHALL move to DONE; from DONE it SHALL return to IDLE after one cycle.
REQ-018 busy SHALL be high exactly while the state is RUN.
REQ-019 done SHALL be high exactly while the state is DONE: one cycle, starting 32/STEP edges after the acceptance edge.
REQ-020 out SHALL be updated only on the edge that enters DONE, and SHALL hold its value until the next completion.
REQ-021 The block SHALL ignore start in RUN and DONE; it does not queue requests, and a start held high re-triggers from IDLE.
REQ-022 Partial results SHALL never be visible on out.

Reset
REQ-023 When rst=1 on an edge, the block SHALL enter IDLE and set busy=0, done=0, out=33'h0, ovf=0, the counter to 0 and the internal borrow to 0.
REQ-024 rst SHALL take priority over start.
REQ-025 A reset during RUN SHALL abort the operation with no done pulse and no update of out.

Configuration
REQ-026 With macro DIFF_BLOCK_OVF_EN defined, ovf SHALL be registered together with out, and SHALL equal (a[31] != b[31]) && (out[31] != a[31]) for the latched operands.
REQ-027 Without DIFF_BLOCK_OVF_EN, ovf SHALL be tied to 0 and no overflow logic SHALL be synthesised.
REQ-028 The port list SHALL be identical with and without DIFF_BLOCK_OVF_EN.

Verification
REQ-029 The bench SHALL apply STEP=1, a=5, b=3, borrow_in=0, start for one cycle -> done 32 edges after acceptance, out=33'h0_00000002, busy high for 32 cycles.
REQ-030 The bench SHALL apply a=0, b=1, borrow_in=0 -> out=33'h1_FFFFFFFF.
REQ-031 The bench SHALL apply a=b=32'h10, borrow_in=1 -> out=33'h1_FFFFFFFF.
REQ-032 The bench SHALL apply, with DIFF_BLOCK_OVF_EN, a=32'h80000000, b=1 -> out=33'h0_7FFFFFFF and ovf=1; without the macro the same stimulus -> ovf=0.
REQ-033 The bench SHALL apply STEP=4, a=32'hFFFFFFFF, b=32'h12345678, with start pulsed again at cycle 3 -> exactly one done at edge 8, out=33'h0_EDCBA987.
REQ-034 The bench SHALL assert rst at RUN cycle 10 -> next cycle busy=0, done never pulses, and out keeps 33'h0; a following start computes correctly.
